// File: rtl/sort_ingress_buffer_pkg.sv
// sort_ingress_buffer_pkg
//   Definitions shared by the ingress buffer and the sorter behind it:
//   default word/address widths, maximum packet length, drop counter
//   width and the ingress FSM state encoding.
package sort_ingress_buffer_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADR_WIDTH_DEF  = 3;
  localparam int MAX_LEN        = 1 << ADR_WIDTH_DEF;
  localparam int DROP_CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_DROP  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/sort_ingress_buffer_if.sv
// sort_ingress_buffer_if
//   Bundles the framed ingress stream (sop/eop/data/val/ready), the sorter
//   busy flag, the framed egress stream and the error/drop status.
//   slave  : seen by sort_ingress_buffer
//   master : seen by the packet source / sorter side (or a bench)
interface sort_ingress_buffer_if
  import sort_ingress_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  sop_i;
  logic                  eop_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  val_i;
  logic                  ready_o;
  logic                  busy_i;
  logic                  sop_o;
  logic                  eop_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  val_o;
  logic                  err_o;
  logic [DROP_CNT_W-1:0] drop_cnt_o;

  modport slave (
    input  sop_i, eop_i, data_i, val_i, busy_i,
    output ready_o, sop_o, eop_o, data_o, val_o, err_o, drop_cnt_o
  );

  modport master (
    output sop_i, eop_i, data_i, val_i, busy_i,
    input  ready_o, sop_o, eop_o, data_o, val_o, err_o, drop_cnt_o
  );

endinterface

// File: rtl/sort_ingress_ram.sv
// sort_ingress_ram
//   Simple dual-port RAM, 2^ADR_WIDTH x DATA_WIDTH, synchronous write and
//   registered read (one cycle read latency). Contents are not reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, registered
module sort_ingress_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADR_WIDTH  = 3
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADR_WIDTH-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADR_WIDTH-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [1 << ADR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sort_ingress_buffer.sv
// sort_ingress_buffer
//   Single-packet store-and-forward stage ahead of the sorter. Captures one
//   sop/eop framed packet, discards malformed or oversize packets, and
//   replays an accepted packet as one contiguous burst once busy_i is low.
//   clk_i    : clock, rising edge
//   srst_n_i : synchronous active-low reset
//   bus_io   : ingress stream, busy_i, egress stream, err_o, drop_cnt_o
module sort_ingress_buffer
  import sort_ingress_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADR_WIDTH  = ADR_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  srst_n_i,
  sort_ingress_buffer_if.slave  bus_io
);

  localparam int            CW      = ADR_WIDTH + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] MAX_CNT = ONE << ADR_WIDTH;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + DROP_CNT_W'(1);
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic                  val_q, val_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  start;
  logic                  we;
  logic [ADR_WIDTH-1:0]  waddr;
  logic [ADR_WIDTH-1:0]  raddr;
  logic [DATA_WIDTH-1:0] rdata;

  sort_ingress_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADR_WIDTH  (ADR_WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (bus_io.data_i),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    len_d    = len_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    err_d    = 1'b0;
    val_d    = 1'b0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    start    = 1'b0;
    we       = 1'b0;
    waddr    = wr_cnt_q[ADR_WIDTH-1:0];
    raddr    = rd_ptr_q[ADR_WIDTH-1:0];

    case (state_q)
      ST_IDLE: begin
        if (bus_io.val_i && bus_io.sop_i) start = 1'b1;
      end
      ST_FILL: begin
        if (bus_io.val_i) begin
          if (bus_io.sop_i) begin
            // New sop abandons the partial packet and restarts capture.
            start  = 1'b1;
            err_d  = 1'b1;
            drop_d = sat_inc(drop_q);
          end else if (wr_cnt_q == MAX_CNT) begin
            // Buffer already full and no eop yet: packet is oversize.
            err_d   = 1'b1;
            drop_d  = sat_inc(drop_q);
            state_d = bus_io.eop_i ? ST_IDLE : ST_DROP;
          end else begin
            we       = 1'b1;
            wr_cnt_d = wr_cnt_q + ONE;
            if (bus_io.eop_i) begin
              len_d   = wr_cnt_q + ONE;
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_DROP: begin
        if (bus_io.val_i) begin
          if (bus_io.sop_i)      start   = 1'b1;
          else if (bus_io.eop_i) state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus_io.val_i) drop_d = sat_inc(drop_q);
        if (!bus_io.busy_i) begin
          raddr    = '0;
          val_d    = 1'b1;
          sop_d    = 1'b1;
          eop_d    = (len_q == ONE);
          rd_ptr_d = ONE;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus_io.val_i) drop_d = sat_inc(drop_q);
        if (rd_ptr_q < len_q) begin
          val_d    = 1'b1;
          eop_d    = (rd_ptr_q == len_q - ONE);
          rd_ptr_d = rd_ptr_q + ONE;
        end
        // Leave once the last word is on the output.
        if (eop_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      we       = 1'b1;
      waddr    = '0;
      wr_cnt_d = ONE;
      if (bus_io.eop_i) begin
        len_d   = ONE;
        state_d = ST_WAIT;
      end else begin
        state_d = ST_FILL;
      end
    end

    ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL) || (state_d == ST_DROP);
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q  <= ST_IDLE;
      wr_cnt_q <= '0;
      len_q    <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      val_q    <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      len_q    <= len_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      val_q    <= val_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
    end
  end

  // --- output stage: RAM read register aligned with val/sop/eop ---
  // The RAM read register is the data output flop; masking with val keeps
  // data_o at zero outside bursts and through reset.
  assign bus_io.data_o     = val_q ? rdata : '0;
  assign bus_io.val_o      = val_q;
  assign bus_io.sop_o      = sop_q;
  assign bus_io.eop_o      = eop_q;
  assign bus_io.err_o      = err_q;
  assign bus_io.drop_cnt_o = drop_q;
  assign bus_io.ready_o    = ready_q & srst_n_i;

endmodule

// File: tb/tb_sort_ingress_buffer.sv
module tb_sort_ingress_buffer;
  import sort_ingress_buffer_pkg::*;

  logic clk = 1'b0;
  logic srst_n;
  int   cyc_n = 0;

  sort_ingress_buffer_if #(.DATA_WIDTH(8)) bus ();

  sort_ingress_buffer #(.DATA_WIDTH(8), .ADR_WIDTH(3)) dut (
    .clk_i    (clk),
    .srst_n_i (srst_n),
    .bus_io   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] stim [$];
  logic [7:0] got_d [$];
  bit         got_sop [$];
  bit         got_eop [$];
  int         got_cyc [$];
  int         err_cnt;
  int         sop_cyc;
  int         eop_cyc;
  int         busy_cyc;
  bit         prev_eop = 1'b0;
  bit         rdy_after_eop;

  always @(negedge clk) begin
    if (bus.val_o) begin
      got_d.push_back(bus.data_o);
      got_sop.push_back(bus.sop_o);
      got_eop.push_back(bus.eop_o);
      got_cyc.push_back(cyc_n);
      if (bus.sop_o && sop_cyc < 0) sop_cyc = cyc_n;
    end
    if (bus.err_o) err_cnt++;
    if (prev_eop) rdy_after_eop = bus.ready_o;
    prev_eop = bus.eop_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_d.delete();
    got_sop.delete();
    got_eop.delete();
    got_cyc.delete();
    err_cnt       = 0;
    sop_cyc       = -1;
    rdy_after_eop = 1'b0;
  endtask

  task automatic idle_in();
    bus.sop_i  = 1'b0;
    bus.eop_i  = 1'b0;
    bus.val_i  = 1'b0;
    bus.data_i = 8'h00;
  endtask

  task automatic send(input bit with_sop, input bit with_eop);
    for (int i = 0; i < stim.size(); i++) begin
      bus.sop_i  = with_sop && (i == 0);
      bus.eop_i  = with_eop && (i == stim.size() - 1);
      bus.data_i = stim[i];
      bus.val_i  = 1'b1;
      if (bus.eop_i) eop_cyc = cyc_n;
      tick(1);
    end
    idle_in();
  endtask

  task automatic do_reset();
    srst_n = 1'b0;
    tick(1);
    srst_n = 1'b1;
    tick(1);
  endtask

  // Compares the captured egress burst with the packet in stim.
  task automatic check_burst(input string tag);
    int n;
    n = stim.size();
    chk({tag, "_len"}, got_d.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got_d.size()) chk($sformatf("%s_d%0d", tag, i), got_d[i], stim[i]);
    if (got_d.size() == n && n > 0) begin
      chk({tag, "_sop_first"}, got_sop[0], 1);
      chk({tag, "_eop_last"}, got_eop[n-1], 1);
      chk({tag, "_contig"}, got_cyc[n-1] - got_cyc[0], n - 1);
      chk({tag, "_sop_cnt"}, got_sop.sum() with (int'(item)), 1);
      chk({tag, "_eop_cnt"}, got_eop.sum() with (int'(item)), 1);
    end
  endtask

  initial begin
    srst_n     = 1'b0;
    bus.busy_i = 1'b0;
    idle_in();
    clear_mon();
    eop_cyc  = 0;
    busy_cyc = 0;

    // Reset values
    tick(2);
    chk("rst_ready", bus.ready_o, 0);
    chk("rst_val", bus.val_o, 0);
    chk("rst_sop", bus.sop_o, 0);
    chk("rst_eop", bus.eop_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_data", bus.data_o, 0);
    chk("rst_drop", bus.drop_cnt_o, 0);
    srst_n = 1'b1;
    tick(1);
    chk("rst_ready_rel", bus.ready_o, 1);

    // Full-size 8-word packet, sorter idle
    clear_mon();
    stim = '{8'hFA, 8'hAA, 8'h56, 8'h12, 8'hAD, 8'hC8, 8'hBC, 8'h05};
    send(1, 1);
    tick(12);
    check_burst("p8");
    chk("p8_lat", sop_cyc - eop_cyc, 2);
    chk("p8_err", err_cnt, 0);
    chk("p8_drop", bus.drop_cnt_o, 0);
    chk("p8_idle_ready", rdy_after_eop, 1);

    // Oversize 9-word packet, then a 3-word packet
    do_reset();
    clear_mon();
    stim = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    send(1, 1);
    tick(4);
    chk("p9_nout", got_d.size(), 0);
    chk("p9_err", err_cnt, 1);
    chk("p9_drop", bus.drop_cnt_o, 1);
    clear_mon();
    stim = '{8'h01, 8'h02, 8'h03};
    send(1, 1);
    tick(8);
    check_burst("p3");
    chk("p3_err", err_cnt, 0);

    // Sorter busy for 20 cycles, 5 refused words meanwhile
    do_reset();
    clear_mon();
    bus.busy_i = 1'b1;
    stim = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    send(1, 1);
    tick(2);
    chk("busy_ready", bus.ready_o, 0);
    for (int i = 0; i < 5; i++) begin
      bus.val_i  = 1'b1;
      bus.data_i = 8'hE0 + 8'(i);
      tick(1);
    end
    idle_in();
    tick(13);
    chk("busy_nout", got_d.size(), 0);
    chk("busy_drop", bus.drop_cnt_o, 5);
    chk("busy_ready2", bus.ready_o, 0);
    bus.busy_i = 1'b0;
    busy_cyc   = cyc_n;
    tick(12);
    chk("busy_lat", sop_cyc - busy_cyc, 1);
    check_burst("busy");
    chk("busy_err", err_cnt, 0);

    // Stray word without sop is ignored; single-word packet
    clear_mon();
    bus.val_i  = 1'b1;
    bus.eop_i  = 1'b1;
    bus.data_i = 8'h99;
    tick(1);
    idle_in();
    tick(2);
    chk("stray_drop", bus.drop_cnt_o, 5);
    stim = '{8'h7E};
    send(1, 1);
    tick(5);
    check_burst("p1");
    chk("p1_lat", sop_cyc - eop_cyc, 2);

    // sop in the middle of a packet
    do_reset();
    clear_mon();
    stim = '{8'h21, 8'h22, 8'h23};
    send(1, 0);
    stim = '{8'h33, 8'h44};
    send(1, 1);
    tick(8);
    chk("midsop_err", err_cnt, 1);
    chk("midsop_drop", bus.drop_cnt_o, 1);
    check_burst("midsop");

    // Reset in the middle of a packet
    clear_mon();
    stim = '{8'h55, 8'h66, 8'h77};
    send(1, 0);
    srst_n = 1'b0;
    tick(1);
    chk("mrst_ready", bus.ready_o, 0);
    chk("mrst_val", bus.val_o, 0);
    chk("mrst_drop", bus.drop_cnt_o, 0);
    chk("mrst_data", bus.data_o, 0);
    srst_n = 1'b1;
    tick(1);
    stim = '{8'h88, 8'h99, 8'hAB};
    send(1, 1);
    tick(8);
    check_burst("mrst");
    chk("mrst_err", err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sort_ingress_buffer.md
# sort_ingress_buffer

Single-packet store-and-forward stage placed directly upstream of the sorting module. It captures one framed packet (sop/eop/val) from a free-running source, checks its length against the sorter's capacity, and replays it as one contiguous burst only when the sorter reports not-busy. Malformed or oversize packets are discarded here, so the sorter only ever sees well-formed packets of 1..2^ADR_WIDTH words.

## Interface
- DATA_WIDTH, 8, word width; matches the sorter
- ADR_WIDTH, 3, log2 of buffer depth; max packet = 2^ADR_WIDTH words; matches the sorter
- clk_i  in  1  clock; all logic on rising edge
- srst_n_i  in  1  reset, synchronous and active-low
- sop_i  in  1  first word of packet, qualified by val_i
- eop_i  in  1  last word of packet, qualified by val_i
- data_i  in  DATA_WIDTH  input word
- val_i  in  1  input word valid
- ready_o  out  1  high when input words are accepted
- busy_i  in  1  sorter busy_o; drain starts only while low
- sop_o  out  1  first output word
- eop_o  out  1  last output word
- data_o  out  DATA_WIDTH  output word
- val_o  out  1  output word valid
- err_o  out  1  one-cycle pulse per discarded packet
- drop_cnt_o  out  16  count of discarded packets and refused words, saturating at 16'hFFFF

## Operation
- States: IDLE, FILL, DROP, WAIT, DRAIN.
- IDLE: ready_o=1. val_i&sop_i stores word at addr 0, wr_cnt=1; if eop_i too, go WAIT (length 1), else FILL. val_i without sop_i: ignore, no count.
- FILL: ready_o=1. val_i stores word at wr_cnt, wr_cnt+1.
  - eop_i with wr_cnt ≤ 2^ADR_WIDTH-1: store, latch length=wr_cnt+1, go WAIT.
  - val_i word with wr_cnt = 2^ADR_WIDTH and no prior eop (oversize): go DROP; if that word has eop_i, go IDLE instead; err_o pulse, drop_cnt+1.
  - val_i&sop_i: partial packet discarded, err_o pulse, drop_cnt+1, new packet restarts at addr 0 (as from IDLE).
- DROP: ready_o=1, words ignored until val_i&eop_i, then IDLE. val_i&sop_i in DROP restarts as from IDLE.
- WAIT: ready_o=0. Any val_i word: refused, drop_cnt+1 per word. busy_i=0 sampled -> DRAIN, rd_ptr=0.
- DRAIN: ready_o=0; refused words counted as in WAIT. One word per cycle, val_o continuous; busy_i ignored once started. Last word -> IDLE.
- wr_cnt and length are ADR_WIDTH+1 bits; addresses ADR_WIDTH bits. drop_cnt saturates, no wrap.
- Reset: state IDLE, counters 0, partial or pending packet discarded; buffer contents need not be cleared.

## Timing
- Reset values: ready_o=1 (0 while srst_n_i low), sop_o=eop_o=val_o=err_o=0, data_o=0, drop_cnt_o=0.
- All outputs registered.
- eop accepted at cycle N -> WAIT at N+1; busy_i=0 at N+1 -> word 0 with sop_o at N+2. Minimum latency eop_i to sop_o: 2 cycles.
- Burst of L words: val_o high L consecutive cycles; sop_o on first, eop_o on last; both high for L=1.
- IDLE reached the cycle after eop_o; ready_o=1 that cycle.
- err_o asserted the cycle after the discarding event.
- Simultaneous discard and refused word cannot occur: refusals occur only in WAIT/DRAIN.

## Structure
- Shared package: state enum, MAX_LEN = 2^ADR_WIDTH, drop counter width (16). The sorter uses the same package.
- One sub-module, sort_ingress_ram: simple dual-port RAM, 2^ADR_WIDTH x DATA_WIDTH, sync write, registered read. Its 1-cycle read latency is absorbed into the 2-cycle eop-to-sop latency.
- FSM, counters, and framing stay in sort_ingress_buffer.

## Test plan
- 8 words FA,AA,56,12,AD,C8,BC,05 (sop on FA, eop on 05), busy_i=0 -> same 8 words in order, sop_o with FA 2 cycles after eop_i, eop_o with 05, val_o 8 contiguous cycles, err_o never asserted.
- 9-word packet, no eop until word 9 -> no output, one err_o pulse, drop_cnt_o=1, then next 3-word packet 01,02,03 forwarded intact.
- busy_i=1 held 20 cycles after an 8-word packet, source sends 5 words meanwhile -> no output, ready_o=0, drop_cnt_o=5; busy_i falls -> sop_o 1 cycle later.
- Single word 7E with sop_i=eop_i=1 -> one cycle of val_o with sop_o=eop_o=1, data_o=7E.
- sop mid-FILL after 3 words, then 2-word packet 33,44 -> err_o pulse, drop_cnt_o=1, output 33,44 only.
- srst_n_i low for one cycle mid-FILL -> all outputs at reset values, no output burst; following packet forwarded normally.
